cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the ALU and LSB write-back sources.

---
 rtl/cdb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two result FIFOs (ALU, LSB) sharing one registered CDB.
// Round-robin pop; optional same-edge bypass when CDB_BYPASS_EN is defined.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module cdb_arbiter #(
  parameter int FIFO_DEPTH     = 2,
  parameter int FIFO_DEPTH_BIT = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic                     alu_valid,
  input  logic [`ROB_SIZE_BIT-1:0] alu_idx,
  input  logic [31:0]              alu_value,
  output logic                     alu_full,
  input  logic                     lsb_valid,
  input  logic [`ROB_SIZE_BIT-1:0] lsb_idx,
  input  logic [31:0]              lsb_value,
  output logic                     lsb_full,
  output logic                     cdb_valid,
  output logic [`ROB_SIZE_BIT-1:0] cdb_idx,
  output logic [31:0]              cdb_value,
  output logic                     cdb_src
);

  localparam int IW = `ROB_SIZE_BIT;

  typedef logic [FIFO_DEPTH_BIT-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_BIT:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);

  logic [IW-1:0] a_idx_q [FIFO_DEPTH];
  logic [31:0]   a_val_q [FIFO_DEPTH];
  logic [IW-1:0] l_idx_q [FIFO_DEPTH];
  logic [31:0]   l_val_q [FIFO_DEPTH];

  ptr_t a_head, a_tail, l_head, l_tail;
  cnt_t a_cnt, l_cnt, a_cnt_n, l_cnt_n;

  logic rr_last;

  logic a_ne, l_ne;
  logic a_push, l_push;
  logic a_cand, l_cand;
  logic a_win, l_win;
  logic a_pop, l_pop;
  logic a_byp, l_byp;
  logic a_wr, l_wr;

  logic [IW-1:0] g_idx;
  logic [31:0]   g_val;

  // grant decision from pre-edge FIFO state (plus same-edge pushes if bypassing)
  always_comb begin
    a_ne   = (a_cnt != '0);
    l_ne   = (l_cnt != '0);
    a_push = alu_valid && !alu_full;
    l_push = lsb_valid && !lsb_full;
`ifdef CDB_BYPASS_EN
    a_cand = a_ne || a_push;
    l_cand = l_ne || l_push;
`else
    a_cand = a_ne;
    l_cand = l_ne;
`endif
    a_win  = a_cand && (!l_cand || rr_last);
    l_win  = l_cand && !a_win;
    a_pop  = a_win && a_ne;
    l_pop  = l_win && l_ne;
    a_byp  = a_win && !a_ne;
    l_byp  = l_win && !l_ne;
    a_wr   = a_push && !a_byp;
    l_wr   = l_push && !l_byp;
  end

  // next occupancy: push and pop on the same edge cancel
  always_comb begin
    a_cnt_n = a_cnt;
    l_cnt_n = l_cnt;
    unique case (1'b1)
      a_wr && !a_pop: a_cnt_n = a_cnt + CNT_ONE;
      !a_wr && a_pop: a_cnt_n = a_cnt - CNT_ONE;
      default:        a_cnt_n = a_cnt;
    endcase
    unique case (1'b1)
      l_wr && !l_pop: l_cnt_n = l_cnt + CNT_ONE;
      !l_wr && l_pop: l_cnt_n = l_cnt - CNT_ONE;
      default:        l_cnt_n = l_cnt;
    endcase
  end

  // winning entry: FIFO head, or the live input when bypassed
  always_comb begin
    g_idx = '0;
    g_val = '0;
    unique case (1'b1)
      a_win: begin
        g_idx = a_ne ? a_idx_q[a_head] : alu_idx;
        g_val = a_ne ? a_val_q[a_head] : alu_value;
      end
      l_win: begin
        g_idx = l_ne ? l_idx_q[l_head] : lsb_idx;
        g_val = l_ne ? l_val_q[l_head] : lsb_value;
      end
      default: begin
        g_idx = '0;
        g_val = '0;
      end
    endcase
  end

  // FIFO storage writes at the tail
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !rob_clear) begin
      if (a_wr) begin
        a_idx_q[a_tail] <= alu_idx;
        a_val_q[a_tail] <= alu_value;
      end
      if (l_wr) begin
        l_idx_q[l_tail] <= lsb_idx;
        l_val_q[l_tail] <= lsb_value;
      end
    end
  end

  // pointers, counts, full flags, rr state and the CDB registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      a_head    <= '0;
      a_tail    <= '0;
      a_cnt     <= '0;
      l_head    <= '0;
      l_tail    <= '0;
      l_cnt     <= '0;
      alu_full  <= 1'b0;
      lsb_full  <= 1'b0;
      rr_last   <= 1'b1;
      cdb_valid <= 1'b0;
      cdb_idx   <= '0;
      cdb_value <= '0;
      cdb_src   <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        a_head    <= '0;
        a_tail    <= '0;
        a_cnt     <= '0;
        l_head    <= '0;
        l_tail    <= '0;
        l_cnt     <= '0;
        alu_full  <= 1'b0;
        lsb_full  <= 1'b0;
        rr_last   <= 1'b1;
        cdb_valid <= 1'b0;
      end else begin
        if (a_wr)  a_tail <= a_tail + PTR_ONE;
        if (a_pop) a_head <= a_head + PTR_ONE;
        if (l_wr)  l_tail <= l_tail + PTR_ONE;
        if (l_pop) l_head <= l_head + PTR_ONE;
        a_cnt    <= a_cnt_n;
        l_cnt    <= l_cnt_n;
        alu_full <= (a_cnt_n == CNT_FULL);
        lsb_full <= (l_cnt_n == CNT_FULL);
        if (a_win || l_win) begin
          cdb_valid <= 1'b1;
          cdb_idx   <= g_idx;
          cdb_value <= g_val;
          cdb_src   <= l_win;
          rr_last   <= l_win;
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus random traffic
// checked against a queue-based model of the CDB arbiter.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module tb_cdb_arbiter;

  localparam int IW = `ROB_SIZE_BIT;
  localparam int D  = 2;
  localparam int DB = 1;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rob_clear;
  logic          alu_valid, lsb_valid;
  logic [IW-1:0] alu_idx, lsb_idx;
  logic [31:0]   alu_value, lsb_value;
  logic          alu_full, lsb_full;
  logic          cdb_valid, cdb_src;
  logic [IW-1:0] cdb_idx;
  logic [31:0]   cdb_value;

  cdb_arbiter #(.FIFO_DEPTH(D), .FIFO_DEPTH_BIT(DB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_clear(rob_clear),
    .alu_valid(alu_valid), .alu_idx(alu_idx),
    .alu_value(alu_value), .alu_full(alu_full),
    .lsb_valid(lsb_valid), .lsb_idx(lsb_idx),
    .lsb_value(lsb_value), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx),
    .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   val;
  } ent_t;

  ent_t          aq[$];
  ent_t          lq[$];
  logic          m_v, m_s, m_rr;
  logic [IW-1:0] m_i;
  logic [31:0]   m_d;

  typedef struct {
    logic          rst, rdy, clr, av, lv;
    logic [IW-1:0] ai, li;
    logic [31:0]   avl, lvl;
    logic          ev, es, eaf, elf;
    logic [IW-1:0] ei;
    logic [31:0]   evl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // reference: FIFOs as queues, results leave in round-robin order
  task automatic model_step(input logic rst, rdy, clr,
                            input logic av, input logic [IW-1:0] ai,
                            input logic [31:0] avl,
                            input logic lv, input logic [IW-1:0] li,
                            input logic [31:0] lvl);
    bit ap, lp, ac, lc;
    ent_t e;
    e = '0;
    if (!rst) begin
      aq.delete(); lq.delete();
      m_v = 0; m_i = '0; m_d = '0; m_s = 0; m_rr = 1;
    end else if (!rdy) begin
      m_v = m_v;
    end else if (clr) begin
      aq.delete(); lq.delete();
      m_v = 0; m_rr = 1;
    end else begin
      ap = av && (aq.size() < D);
      lp = lv && (lq.size() < D);
      ac = aq.size() > 0;
      lc = lq.size() > 0;
`ifdef CDB_BYPASS_EN
      if (ap) ac = 1;
      if (lp) lc = 1;
`endif
      m_v = ac || lc;
      if (ac && (!lc || m_rr)) begin
        if (aq.size() > 0) e = aq.pop_front();
        else begin e = '{ai, avl}; ap = 0; end
        m_s = 0;
      end else if (lc) begin
        if (lq.size() > 0) e = lq.pop_front();
        else begin e = '{li, lvl}; lp = 0; end
        m_s = 1;
      end
      if (m_v) begin
        m_i = e.idx; m_d = e.val; m_rr = m_s;
      end
      if (ap) aq.push_back('{ai, avl});
      if (lp) lq.push_back('{li, lvl});
    end
  endtask

  task automatic cyc(input logic rst, rdy, clr,
                     input logic av, input logic [IW-1:0] ai,
                     input logic [31:0] avl,
                     input logic lv, input logic [IW-1:0] li,
                     input logic [31:0] lvl);
    rst_in = rst; rdy_in = rdy; rob_clear = clr;
    alu_valid = av; alu_idx = ai; alu_value = avl;
    lsb_valid = lv; lsb_idx = li; lsb_value = lvl;
    @(posedge clk_in);
    #1;
    model_step(rst, rdy, clr, av, ai, avl, lv, li, lvl);
    chk("model_valid", 64'(cdb_valid), 64'(m_v));
    chk("model_idx",   64'(cdb_idx),   64'(m_i));
    chk("model_value", 64'(cdb_value), 64'(m_d));
    chk("model_src",   64'(cdb_src),   64'(m_s));
    chk("model_afull", 64'(alu_full),  64'(aq.size() == D));
    chk("model_lfull", 64'(lsb_full),  64'(lq.size() == D));
  endtask

  function automatic vec_t mk(input logic rst, rdy, clr, av,
                              input int ai, input logic lv,
                              input int li, input logic ev,
                              input int ei, input logic es, eaf, elf);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.clr = clr;
    v.av = av; v.ai = IW'(ai); v.avl = 32'hA000_0000 + 32'(ai);
    v.lv = lv; v.li = IW'(li); v.lvl = 32'hB000_0000 + 32'(li);
    v.ev = ev; v.ei = IW'(ei); v.es = es;
    v.eaf = eaf; v.elf = elf;
    v.evl = !ev ? 32'h0 :
            (es ? 32'hB000_0000 : 32'hA000_0000) + 32'(ei);
    return v;
  endfunction

  initial begin
    vec_t v;
    bit   ap, lp;
    rst_in = 0; rdy_in = 1; rob_clear = 0;
    alu_valid = 0; alu_idx = '0; alu_value = '0;
    lsb_valid = 0; lsb_idx = '0; lsb_value = '0;
    m_v = 0; m_s = 0; m_rr = 1; m_i = '0; m_d = '0;

    // rst rdy clr av ai lv li | ev ei es afull lfull
    tbl.push_back(mk(0,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(0,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,3, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,3,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(0,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,1, 1,9,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,2, 1,10, 1,1,0, 0,1));
    tbl.push_back(mk(1,1,0, 1,3, 0,0,  1,9,1, 1,0));
    tbl.push_back(mk(1,1,0, 0,0, 1,11, 1,2,0, 0,1));
    tbl.push_back(mk(1,1,0, 1,4, 0,0,  1,10,1, 1,0));
    tbl.push_back(mk(1,1,0, 0,0, 1,12, 1,3,0, 0,1));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,11,1, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,4,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,12,1, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,5, 1,13, 0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,6, 0,0,  1,5,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,7, 0,0,  1,13,1, 1,0));
    tbl.push_back(mk(1,1,0, 1,8, 0,0,  1,6,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,9, 0,0,  1,7,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,9,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,1, 1,2,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,3, 1,4,  1,2,1, 1,0));
    tbl.push_back(mk(1,1,0, 0,0, 1,5,  1,1,0, 0,1));
    tbl.push_back(mk(1,1,0, 1,6, 0,0,  1,4,1, 1,0));
    tbl.push_back(mk(1,1,1, 0,0, 1,8,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 1,14, 1,5, 0,0,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,14,0, 0,0));
    tbl.push_back(mk(1,0,0, 1,15, 0,0, 1,14,0, 0,0));
    tbl.push_back(mk(1,0,0, 1,15, 0,0, 1,14,0, 0,0));
    tbl.push_back(mk(1,0,0, 1,15, 0,0, 1,14,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  1,5,1, 0,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,0,0, 0,0));
    tbl[2].avl = 32'h1234;
    tbl[3].evl = 32'h1234;

    foreach (tbl[k]) begin
      v = tbl[k];
      cyc(v.rst, v.rdy, v.clr, v.av, v.ai, v.avl, v.lv, v.li, v.lvl);
`ifndef CDB_BYPASS_EN
      chk($sformatf("vec%0d_valid", k), 64'(cdb_valid), 64'(v.ev));
      chk($sformatf("vec%0d_afull", k), 64'(alu_full), 64'(v.eaf));
      chk($sformatf("vec%0d_lfull", k), 64'(lsb_full), 64'(v.elf));
      if (v.ev || !v.rst) begin
        chk($sformatf("vec%0d_idx", k), 64'(cdb_idx), 64'(v.ei));
        chk($sformatf("vec%0d_value", k), 64'(cdb_value), 64'(v.evl));
        chk($sformatf("vec%0d_src", k), 64'(cdb_src), 64'(v.es));
      end
`endif
    end

    for (int n = 0; n < 3000; n++) begin
      ap = ($urandom_range(1, 0) == 1);
      lp = ($urandom_range(1, 0) == 1);
      if (aq.size() == D && $urandom_range(19, 0) != 0) ap = 0;
      if (lq.size() == D && $urandom_range(19, 0) != 0) lp = 0;
      cyc($urandom_range(299, 0) != 0,
          $urandom_range(9, 0) != 0,
          $urandom_range(32, 0) == 0,
          ap, IW'($urandom), $urandom,
          lp, IW'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
